im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_pkg.sv | 30 +++
 rtl/im_word_packer.sv | 32 +++
 rtl/im_loader.sv | 135 +++++++++++++
 tb/tb_im_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, code segment base,
// and the IM_LOADER_CHECKSUM_EN build option (adds a trailing XOR checksum byte).
package im_loader_pkg;

  localparam logic [31:0] CODE_SEG_PC = 32'h0000_3000;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CKSUM  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } im_state_e;
`else
  localparam bit CHECKSUM_EN = 1'b0;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd4,
    ERR    = 3'd5
  } im_state_e;
`endif

endpackage

// File: rtl/im_word_packer.sv
// Big-endian byte-to-word packer: three bytes are held, the fourth completes the word
// combinationally so the loader can register it on the same edge.
module im_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] sh_q;
  logic [1:0]  cnt_q;

  assign word_o       = {sh_q, byte_i};
  assign word_valid_o = strobe_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (strobe_i) begin
      sh_q  <= {sh_q[15:0], byte_i};
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Byte-stream program loader: parses a word-count header and big-endian words into the
// instruction memory, holding the CPU in reset until done. Option: IM_LOADER_CHECKSUM_EN.
//
// Handshake: a byte is consumed on a rising clk edge where in_valid && in_ready;
// in_valid may drop on any cycle and in_ready never depends on in_valid.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_DEPTH = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output im_state_e         state_o
);

  localparam int CNT_W = ADDR_W + 1;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam im_state_e PAYLOAD_END = CKSUM;
`else
  localparam im_state_e PAYLOAD_END = DONE;
`endif

  im_state_e         state_q, state_d;
  logic [7:0]        hdr_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic        accept;
  logic        strobe;
  logic [15:0] n_full;
  logic        last_word;
  logic [31:0] word;
  logic        word_valid;

  // Gating with reset keeps in_ready low for the whole time reset is held.
  assign in_ready  = !reset && (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA
`ifdef IM_LOADER_CHECKSUM_EN
                                || state_q == CKSUM
`endif
                               );
  assign accept    = in_valid && in_ready;
  assign strobe    = accept && (state_q == DATA);
  assign n_full    = {hdr_q, in_data};
  assign last_word = (wcnt_q + CNT_W'(1)) == n_q;

  im_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (in_data),
    .strobe_i     (strobe),
    .clear_i      (state_q != DATA),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_HI: if (accept) state_d = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (n_full == 16'd0)               state_d = PAYLOAD_END;
          else if (32'(n_full) > IM_DEPTH)   state_d = ERR;
          else                               state_d = DATA;
        end
      end
      DATA:   if (word_valid && last_word) state_d = PAYLOAD_END;
`ifdef IM_LOADER_CHECKSUM_EN
      CKSUM:  if (accept) state_d = (in_data == xor_q) ? DONE : ERR;
`endif
      DONE:   state_d = DONE;
      ERR:    state_d = ERR;
      default: state_d = HDR_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR_HI;
      hdr_q   <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= word_valid;
      if (accept && state_q == HDR_HI) hdr_q <= in_data;
      if (accept && state_q == HDR_LO) begin
        n_q    <= CNT_W'(n_full);
        wcnt_q <= '0;
      end
      if (word_valid) begin
        wcnt_q  <= wcnt_q + CNT_W'(1);
        waddr_q <= wcnt_q[ADDR_W-1:0];
        wdata_q <= word;
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       xor_q <= '0;
    else if (strobe) xor_q <= xor_q ^ in_data;
  end
`endif

  assign im_we     = we_q;
  assign im_waddr  = waddr_q;
  assign im_wdata  = wdata_q;
  // The final write pulse occupies the first DONE cycle, so done follows it by one cycle.
  assign done      = (state_q == DONE) && !we_q;
  assign cpu_reset = !done;
  assign error     = (state_q == ERR);
  assign state_o   = state_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: framed byte streams, write capture, done/error timing.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  im_state_e         state_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  im_loader #(.IM_DEPTH(1024), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .state_o   (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write capture
  always @(negedge clk) begin
    if (im_we) got_q.push_back({im_waddr, im_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_im_we"},     im_we,     0);
    chk({tag, "_im_waddr"},  im_waddr,  0);
    chk({tag, "_im_wdata"},  im_wdata,  0);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_error"},     error,     0);
    chk({tag, "_state"},     state_o,   HDR_HI);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // driver: present a byte and hold it until consumed (bounded)
  task automatic send(input logic [7:0] b);
    logic taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        taken = 1'b1;
      end
    end
    chk("send_accept", taken, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame2(input bit gaps);
    logic [7:0] fr [10];
    fr = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    for (int i = 0; i < 10; i++) begin
      send(fr[i]);
      if (gaps) idle(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_frame2();
    exp_q.push_back({10'd0, 32'h2401_0005});
    exp_q.push_back({10'd1, 32'h0000_0008});
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk(tag, got_q[i], exp_q[i]);
  endtask

  initial begin
    // 1: back-to-back frame, exact pulse/done timing
    do_reset();
    expect_frame2();
    send_frame2(1'b0);
    @(negedge clk);
    chk("b2b_last_we",    im_we,    1);
    chk("b2b_last_addr",  im_waddr, 1);
    chk("b2b_last_data",  im_wdata, 32'h0000_0008);
    chk("b2b_done_early", done,     0);
    @(negedge clk);
    chk("b2b_we_off",    im_we,     0);
    chk("b2b_done",      done,      1);
    chk("b2b_cpu_reset", cpu_reset, 0);
    chk("b2b_in_ready",  in_ready,  0);
    chk("b2b_addr_hold", im_waddr,  1);
    idle(3);
    chk_writes("b2b_writes");
    chk("b2b_done_sticky", done, 1);

    // 2: same frame with in_valid toggling
    do_reset();
    expect_frame2();
    send_frame2(1'b1);
    idle(3);
    chk_writes("gap_writes");
    chk("gap_done", done, 1);

    // 3: oversize header
    do_reset();
    send(8'h04);
    send(8'h01);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_error",     error,     1);
    chk("ovf_in_ready",  in_ready,  0);
    chk("ovf_cpu_reset", cpu_reset, 1);
    chk("ovf_state",     state_o,   ERR);
    idle(4);
    chk("ovf_error_sticky", error, 1);
    chk_writes("ovf_writes");

    // 4: empty program
    do_reset();
    send(8'h00);
    send(8'h00);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef IM_LOADER_CHECKSUM_EN
    chk("n0_state", state_o, CKSUM);
    send(8'h00);
    in_valid = 1'b0;
    @(negedge clk);
`endif
    chk("n0_done",      done,      1);
    chk("n0_cpu_reset", cpu_reset, 0);
    idle(3);
    chk_writes("n0_writes");

    // 5: reset in the middle of word 0, then a full frame
    do_reset();
    send(8'h00);
    send(8'h02);
    send(8'h24);
    send(8'h01);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    expect_frame2();
    send_frame2(1'b0);
    idle(3);
    chk_writes("midrst_writes");
    chk("midrst_done", done, 1);

    // 6: full-capacity program (N = 1024), word k carries value k
    do_reset();
    send(8'h04);
    send(8'h00);
    for (int k = 0; k < 1024; k++) begin
      logic [15:0] kk;
      kk = 16'(k);
      send(8'h00);
      send(8'h00);
      send(kk[15:8]);
      send(kk[7:0]);
      exp_q.push_back({10'(k), 32'(k)});
    end
    in_valid = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
    // XOR of all payload bytes of words 0..1023 (low bytes cycle 0..255 four times, high bytes pair up)
    send(8'h00);
    in_valid = 1'b0;
`endif
    idle(3);
    chk_writes("full_writes");
    chk("full_done",  done,  1);
    chk("full_error", error, 0);

`ifdef IM_LOADER_CHECKSUM_EN
    // 7: checksum: 24^01^00^05^00^00^00^08 = 28
    do_reset();
    expect_frame2();
    send_frame2(1'b0);
    send(8'h28);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ck_ok_done",  done,  1);
    chk("ck_ok_error", error, 0);
    chk_writes("ck_ok_writes");

    do_reset();
    expect_frame2();
    send_frame2(1'b0);
    send(8'h2D);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ck_bad_error",     error,     1);
    chk("ck_bad_done",      done,      0);
    chk("ck_bad_cpu_reset", cpu_reset, 1);
    chk_writes("ck_bad_writes");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    total_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
